inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Instruction-memory responder for the CPU fetch port: it holds `openmips` in reset while a boot image arrives as a byte stream, packs the bytes into 32-bit words, then serves `rom_ce`/`rom_addr` fetches with zero-wait combinational read data. It sits between the board-level boot source (UART/JTAG byte pump) and the core's `rom_addr_o`/`rom_ce_o`/`rom_data_i` pins, replacing the static instruction ROM.

## Interface
- `ADDR_W`, 10, log2 of memory depth in 32-bit words (default 1024 words)
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `ld_valid_i`  in  1  boot byte valid
- `ld_data_i`  in  8  boot byte
- `ld_last_i`  in  1  qualifies final byte of image (sampled with `ld_valid_i`)
- `ld_ready_o`  out  1  loader accepts a byte this cycle
- `rom_ce_i`  in  1  fetch enable from core
- `rom_addr_i`  in  32  byte address from core PC
- `rom_data_o`  out  32  instruction word to core
- `cpu_rst_o`  out  1  reset to core, 1 = hold core in reset (registered)
- `boot_done_o`  out  1  image loaded, core running
- `load_err_o`  out  1  image overflowed memory
- `word_count_o`  out  ADDR_W+1  words written so far

## Operation
- States: LOAD (reset state), RUN, ERR. Byte transfer = `ld_valid_i & ld_ready_o` at a rising edge.
- `ld_ready_o` = 1 in LOAD and ERR, 0 in RUN and while `rst`=0.
- Byte packing big-endian: byte lane counter `lane` 0..3; lane 0 -> bits [31:24], lane 3 -> bits [7:0]. Counter wraps 3 -> 0.
- Word write: on transfer with `lane`=3, mem[`wr_ptr`] <= assembled word, `wr_ptr`++, `word_count_o`++, `lane`<=0.
- LOAD, transfer with `ld_last_i`=1: current word written with unfilled low lanes zero-padded (even if `lane`<3), `lane`<=0, next state RUN.
- Overflow: transfer in LOAD when `word_count_o` = 2^ADDR_W -> byte dropped, next state ERR. ERR drains (ready=1, bytes discarded), `load_err_o`=1, core stays in reset; exit only by `rst`.
- RUN: `rom_data_o` = mem[`rom_addr_i`[ADDR_W+1:2]] when `rom_ce_i`=1 and word index < `word_count_o` and `rom_addr_i`[31:ADDR_W+2] = 0; otherwise 32'h0. `rom_addr_i`[1:0] ignored. In LOAD/ERR `rom_data_o` = 0.
- `cpu_rst_o` = 1 in LOAD/ERR, 0 in RUN. `boot_done_o` = (state == RUN).
- Memory array not reset; reads gated by `word_count_o`, so stale contents never reach the core.

## Timing
- While `rst`=0 at an edge: state LOAD, `lane`=0, `wr_ptr`=0, `word_count_o`=0, `cpu_rst_o`=1, `boot_done_o`=0, `load_err_o`=0; combinational outputs `ld_ready_o`=0, `rom_data_o`=0.
- First byte accepted on the first edge after `rst` returns to 1.
- Word visible to reads the cycle after the edge that writes it.
- Last-byte edge: word written, state -> RUN, `cpu_rst_o` falls, `boot_done_o` rises, all on that same edge. Core fetches from PC 0 from the next cycle; fetch read is same-cycle combinational (0 wait states).
- `rst` mid-load: partial word discarded, count cleared, reload starts from word 0.
- `ld_last_i` without `ld_valid_i`: ignored. `ld_valid_i` in RUN: ignored, no state change.

## Test plan
- Load 8 bytes 3C,01,12,34,34,21,56,78 with last on byte 8 -> `word_count_o`=2, RUN, fetch addr 0 -> 3C011234, addr 4 -> 34215678, addr 8 -> 0, `rom_ce_i`=0 -> 0.
- Load 5 bytes AA,BB,CC,DD,EE last on 5th -> word1 = EE000000, `word_count_o`=2, `cpu_rst_o` 1->0 on the last-byte edge.
- `ADDR_W`=2: send 17 bytes -> after 16th byte count=4, 17th byte -> ERR, `load_err_o`=1, `cpu_rst_o` stays 1, `ld_ready_o` stays 1.
- Pull `rst` low after 6 bytes, release, load 4 bytes 11,22,33,44 last -> count=1, addr 0 -> 11223344, addr 4 -> 0 (stale word masked).
- Gapped `ld_valid_i` (1 byte every 3 cycles), `ld_valid_i` held in RUN, fetch with `rom_addr_i`=32'h0000_1000 (`ADDR_W`=10) -> packing unaffected by gaps, RUN ignores bytes, out-of-range fetch -> 0.
- Full system: load a 4-instruction `ori`/`or` program, run `openmips` -> expected regfile writeback sequence after `cpu_rst_o` deasserts.

Source files
------------

// File: rtl/inst_rom_loader.sv
// Boot-image loader and zero-wait instruction memory for the openmips fetch port.
// Holds the core in reset while a big-endian byte stream fills memory, then serves fetches.
module inst_rom_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              cpu_rst_o,
  output logic              boot_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StLoad, StRun, StErr} state_e;

  state_e          state_q;
  logic [1:0]      lane_q;
  logic [23:0]     hold_q;
  logic [ADDR_W:0] count_q;
  logic            cpu_rst_q;
  logic            boot_done_q;
  logic            load_err_q;
  logic [31:0]     mem [Depth];

  logic              xfer;
  logic              full;
  logic              mem_we;
  logic [31:0]       word;
  logic [ADDR_W-1:0] rd_idx;
  logic              addr_hi_zero;
  logic              unused_addr;

  assign ld_ready_o   = rst && (state_q != StRun);
  assign xfer         = ld_valid_i && ld_ready_o;
  // Count tops out at Depth, so its MSB alone flags a full memory.
  assign full         = count_q[ADDR_W];
  assign mem_we       = xfer && (state_q == StLoad) && !full &&
                        ((lane_q == 2'd3) || ld_last_i);

  assign cpu_rst_o    = cpu_rst_q;
  assign boot_done_o  = boot_done_q;
  assign load_err_o   = load_err_q;
  assign word_count_o = count_q;

  // Incoming byte lands in the current lane; unfilled lower lanes are zero.
  always_comb begin
    word = '0;
    case (lane_q)
      2'd0:    word = {ld_data_i, 24'h0};
      2'd1:    word = {hold_q[23:16], ld_data_i, 16'h0};
      2'd2:    word = {hold_q[23:8], ld_data_i, 8'h0};
      default: word = {hold_q, ld_data_i};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StLoad;
      lane_q      <= 2'd0;
      hold_q      <= '0;
      count_q     <= '0;
      cpu_rst_q   <= 1'b1;
      boot_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else if (xfer && (state_q == StLoad)) begin
      if (full) begin
        state_q    <= StErr;
        load_err_q <= 1'b1;
      end else begin
        case (lane_q)
          2'd0:    hold_q[23:16] <= ld_data_i;
          2'd1:    hold_q[15:8]  <= ld_data_i;
          2'd2:    hold_q[7:0]   <= ld_data_i;
          default: ;
        endcase
        if (mem_we) begin
          count_q <= count_q + 1'b1;
          lane_q  <= 2'd0;
        end else begin
          lane_q  <= lane_q + 2'd1;
        end
        if (ld_last_i) begin
          state_q     <= StRun;
          cpu_rst_q   <= 1'b0;
          boot_done_q <= 1'b1;
        end
      end
    end
  end

  // Array is never reset; reads below are gated by the word count instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[ADDR_W-1:0]] <= word;
    end
  end

  assign rd_idx       = rom_addr_i[ADDR_W+1:2];
  assign addr_hi_zero = (rom_addr_i[31:ADDR_W+2] == '0);
  assign unused_addr  = ^rom_addr_i[1:0];

  always_comb begin
    rom_data_o = '0;
    if (rst && (state_q == StRun) && rom_ce_i && addr_hi_zero &&
        ({1'b0, rd_idx} < count_q)) begin
      rom_data_o = mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: two instances (ADDR_W=10 and ADDR_W=2) checked
// against a byte-list reference model; a negedge monitor drains the expectation queue.
module tb_inst_rom_loader;

  localparam int unsigned AwA = 10;
  localparam int unsigned AwB = 2;
  localparam int KReady = 0, KCpuRst = 1, KDone = 2, KErr = 3, KCount = 4, KData = 5;

  typedef struct {
    int          sel;
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int n_checks = 0;
  int n_err    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid [2];
  logic [7:0]  ld_data  [2];
  logic        ld_last  [2];
  logic        rom_ce   [2];
  logic [31:0] rom_addr [2];
  logic        ready    [2];
  logic        cpu_rst  [2];
  logic        done     [2];
  logic        err      [2];
  logic [31:0] rdata    [2];
  logic [AwA:0] cnt_a;
  logic [AwB:0] cnt_b;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(AwA)) dut_a (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid[0]), .ld_data_i(ld_data[0]),
    .ld_last_i(ld_last[0]), .ld_ready_o(ready[0]), .rom_ce_i(rom_ce[0]),
    .rom_addr_i(rom_addr[0]), .rom_data_o(rdata[0]), .cpu_rst_o(cpu_rst[0]),
    .boot_done_o(done[0]), .load_err_o(err[0]), .word_count_o(cnt_a)
  );

  inst_rom_loader #(.ADDR_W(AwB)) dut_b (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid[1]), .ld_data_i(ld_data[1]),
    .ld_last_i(ld_last[1]), .ld_ready_o(ready[1]), .rom_ce_i(rom_ce[1]),
    .rom_addr_i(rom_addr[1]), .rom_data_o(rdata[1]), .cpu_rst_o(cpu_rst[1]),
    .boot_done_o(done[1]), .load_err_o(err[1]), .word_count_o(cnt_b)
  );

  // Reference model: image is a list of words, partial word kept as a byte accumulator.
  logic [31:0] m_mem [2][1024];
  int          m_cnt  [2];
  int          m_nb   [2];
  logic [31:0] m_part [2];
  bit          m_run  [2];
  bit          m_err  [2];

  function automatic int depth(int s);
    return (s == 1) ? (1 << AwB) : (1 << AwA);
  endfunction

  function automatic int aw(int s);
    return (s == 1) ? AwB : AwA;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_nb[s] = 0; m_part[s] = '0; m_run[s] = 0; m_err[s] = 0;
    end
  endfunction

  function automatic void model_byte(int s, logic [7:0] b, bit last);
    if (m_run[s] || m_err[s]) return;
    if (m_cnt[s] == depth(s)) begin
      m_err[s] = 1;
      return;
    end
    m_part[s] = m_part[s] | ({24'h0, b} << (24 - 8 * m_nb[s]));
    m_nb[s]++;
    if (m_nb[s] == 4 || last) begin
      m_mem[s][m_cnt[s]] = m_part[s];
      m_cnt[s]++;
      m_part[s] = '0;
      m_nb[s] = 0;
      if (last) m_run[s] = 1;
    end
  endfunction

  function automatic logic [31:0] pred_data(int s);
    logic [31:0] a;
    a = rom_addr[s];
    if (!rst || !m_run[s] || !rom_ce[s]) return 32'h0;
    if ((a >> (aw(s) + 2)) != 0) return 32'h0;
    if (int'(a >> 2) >= m_cnt[s]) return 32'h0;
    return m_mem[s][int'(a >> 2)];
  endfunction

  function automatic logic [31:0] actual(int s, int k);
    case (k)
      KReady:  return {31'h0, ready[s]};
      KCpuRst: return {31'h0, cpu_rst[s]};
      KDone:   return {31'h0, done[s]};
      KErr:    return {31'h0, err[s]};
      KCount:  return (s == 1) ? 32'(cnt_b) : 32'(cnt_a);
      default: return rdata[s];
    endcase
  endfunction

  // Monitor: compares every queued expectation against the outputs presented this cycle.
  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      act = actual(it.sel, it.kind);
      n_checks++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s (dut%0d kind%0d): got %h expected %h", it.name, it.sel, it.kind,
                 act, it.exp);
      end
    end
  end

  task automatic push(int s, int k, logic [31:0] e, string name);
    item_t it;
    it.sel = s; it.kind = k; it.exp = e; it.name = name;
    sb.push_back(it);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic status(int s, string name);
    push(s, KReady,  32'(rst && !m_run[s]), {name, "_ready"});
    push(s, KCpuRst, 32'(!m_run[s]), {name, "_cpu_rst"});
    push(s, KDone,   32'(m_run[s]), {name, "_done"});
    push(s, KErr,    32'(m_err[s]), {name, "_err"});
    push(s, KCount,  32'(m_cnt[s]), {name, "_count"});
    settle();
  endtask

  task automatic fetch(int s, logic ce, logic [31:0] addr, string name);
    rom_ce[s] = ce;
    rom_addr[s] = addr;
    push(s, KData, pred_data(s), name);
    settle();
  endtask

  task automatic fetch_k(int s, logic [31:0] addr, logic [31:0] e, string name);
    rom_ce[s] = 1'b1;
    rom_addr[s] = addr;
    push(s, KData, e, name);
    settle();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int s, logic [7:0] b, bit last);
    ld_valid[s] = 1'b1;
    ld_data[s]  = b;
    ld_last[s]  = last;
    step();
    if (rst) model_byte(s, b, last);
    ld_valid[s] = 1'b0;
    ld_last[s]  = 1'b0;
  endtask

  // Idle cycle with a stray ld_last, which must be ignored without ld_valid.
  task automatic idle(int s);
    ld_valid[s] = 1'b0;
    ld_last[s]  = 1'($urandom_range(0, 1));
    step();
    ld_last[s]  = 1'b0;
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      ld_valid[s] = 1'b0; ld_last[s] = 1'b0; ld_data[s] = 8'h0;
      rom_ce[s] = 1'b1; rom_addr[s] = 32'h0;
    end
    repeat (cycles) step();
    model_reset();
    status(0, "rst_a");
    status(1, "rst_b");
    fetch(0, 1'b1, 32'h0, "rst_fetch_a");
    rst = 1'b1;
    status(0, "post_rst_a");
  endtask

  initial begin
    logic [7:0] img[$];
    int n;
    int s;
    logic [31:0] addr;

    for (int i = 0; i < 2; i++) begin
      ld_valid[i] = 1'b0; ld_data[i] = 8'h0; ld_last[i] = 1'b0;
      rom_ce[i] = 1'b0; rom_addr[i] = 32'h0;
    end

    // Two-word program image.
    do_reset(2);
    img = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};
    for (int i = 0; i < 8; i++) send(0, img[i], i == 7);
    push(0, KCount, 32'd2, "t1_count_k");
    status(0, "t1");
    fetch_k(0, 32'h0, 32'h3C01_1234, "t1_addr0");
    fetch_k(0, 32'h4, 32'h3421_5678, "t1_addr4");
    fetch_k(0, 32'h7, 32'h3421_5678, "t1_addr7_lowbits");
    fetch_k(0, 32'h8, 32'h0, "t1_addr8");
    fetch(0, 1'b0, 32'h0, "t1_ce0");

    // Partial final word is zero-padded; core released on the last-byte edge.
    do_reset(1);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 4; i++) send(0, img[i], 1'b0);
    push(0, KCpuRst, 32'd1, "t2_cpu_rst_before");
    status(0, "t2_pre");
    send(0, img[4], 1'b1);
    push(0, KCpuRst, 32'd0, "t2_cpu_rst_after");
    status(0, "t2_post");
    fetch_k(0, 32'h0, 32'hAABB_CCDD, "t2_word0");
    fetch_k(0, 32'h4, 32'hEE00_0000, "t2_word1");

    // Overflow on the small instance.
    do_reset(1);
    for (int i = 0; i < 16; i++) send(1, 8'($urandom), 1'b0);
    push(1, KCount, 32'd4, "t3_count_full");
    status(1, "t3_full");
    send(1, 8'h5A, 1'b0);
    push(1, KErr, 32'd1, "t3_err_k");
    status(1, "t3_err");
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b1);
    push(1, KReady, 32'd1, "t3_drain_ready");
    push(1, KCpuRst, 32'd1, "t3_drain_cpu_rst");
    status(1, "t3_drain");
    fetch(1, 1'b1, 32'h0, "t3_fetch_err");

    // Reset mid-load; stale word 1 must stay masked.
    do_reset(1);
    for (int i = 0; i < 6; i++) send(0, 8'(i + 1), 1'b0);
    do_reset(2);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) send(0, img[i], i == 3);
    push(0, KCount, 32'd1, "t4_count_k");
    status(0, "t4");
    fetch_k(0, 32'h0, 32'h1122_3344, "t4_addr0");
    fetch_k(0, 32'h4, 32'h0, "t4_stale");

    // Gapped bytes, bytes offered in RUN, out-of-range fetch.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      send(0, 8'($urandom), i == 7);
      idle(0);
      idle(0);
    end
    status(0, "t5_loaded");
    for (int i = 0; i < 5; i++) begin
      ld_valid[0] = 1'b1;
      ld_data[0]  = 8'($urandom);
      ld_last[0]  = 1'($urandom_range(0, 1));
      step();
      model_byte(0, ld_data[0], ld_last[0]);
    end
    ld_valid[0] = 1'b0;
    ld_last[0]  = 1'b0;
    status(0, "t5_run_hold");
    fetch(0, 1'b1, 32'h0, "t5_addr0");
    fetch(0, 1'b1, 32'h4, "t5_addr4");
    fetch_k(0, 32'h0000_1000, 32'h0, "t5_oob");

    // Randomized images against the model.
    for (int iter = 0; iter < 12; iter++) begin
      s = iter % 2;
      do_reset(1);
      n = (s == 1) ? $urandom_range(1, 22) : $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        send(s, 8'($urandom), i == n - 1);
        repeat ($urandom_range(0, 2)) idle(s);
      end
      status(s, "rnd_status");
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) == 0) addr = $urandom;
        else addr = 32'($urandom_range(0, 4 * m_cnt[s] + 7));
        fetch(s, 1'($urandom_range(0, 5) != 0), addr, "rnd_fetch");
      end
    end

    settle();
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
